// File: rtl/async_fifo_package.sv
// Shared definitions for the async FIFO and its read-side width converter.
package async_fifo_package;

  localparam int DEFAULT_UPSIZE_RATIO = 4;
  localparam int MAX_UPSIZE_RATIO     = 32;

  // Thermometer mask with the low `count` lanes set, clipped to `ratio` lanes.
  function automatic logic [MAX_UPSIZE_RATIO-1:0] lanes_to_keep(input int count, input int ratio);
    logic [MAX_UPSIZE_RATIO-1:0] keep;
    keep = '0;
    for (int i = 0; i < MAX_UPSIZE_RATIO; i++) begin
      keep[i] = (i < count) && (i < ratio);
    end
    return keep;
  endfunction

endpackage

// File: rtl/fifo_read_upsizer_if.sv
// Narrow-in / wide-out handshake bundle for the read-side upsizer.
// FIFO_READ_UPSIZER_LAST_EN adds in_last, out_last and out_keep.
interface fifo_read_upsizer_if
  import async_fifo_package::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = DEFAULT_UPSIZE_RATIO
);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH*RATIO-1:0] out_data;
`ifdef FIFO_READ_UPSIZER_LAST_EN
  logic                        in_last;
  logic                        out_last;
  logic [RATIO-1:0]            out_keep;
`endif

  modport master (
    output in_valid, in_data, out_ready,
`ifdef FIFO_READ_UPSIZER_LAST_EN
    output in_last,
    input  out_last, out_keep,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef FIFO_READ_UPSIZER_LAST_EN
    input  in_last,
    output out_last, out_keep,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fifo_read_upsizer.sv
// Packs RATIO narrow FIFO beats into one registered wide word; word visible the cycle after its last beat.
// Only the completing beat stalls, when the output register is full and not draining. Macro: FIFO_READ_UPSIZER_LAST_EN.
module fifo_read_upsizer
  import async_fifo_package::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = DEFAULT_UPSIZE_RATIO
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_read_upsizer_if.slave bus
);
  localparam int CW = $clog2(RATIO);
  localparam int WW = DATA_WIDTH * RATIO;

  logic [CW-1:0]                   cnt;
  logic [DATA_WIDTH*(RATIO-1)-1:0] acc;
  logic [WW-1:0]                   out_data_q;
  logic                            out_valid_q;
  logic                            final_lane;
  logic                            complete;
  logic                            accept;
  logic [WW-1:0]                   acc_ext;
  logic [WW-1:0]                   word;

  assign final_lane = (cnt == CW'(RATIO - 1));
`ifdef FIFO_READ_UPSIZER_LAST_EN
  assign complete = final_lane || bus.in_last;
`else
  assign complete = final_lane;
`endif

  assign bus.in_ready  = rst_n && (!complete || !out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign acc_ext       = {{DATA_WIDTH{1'b0}}, acc};

  // Filled lanes come from acc, the current beat lands in lane cnt, lanes above it stay zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < cnt) begin
        word[i*DATA_WIDTH +: DATA_WIDTH] = acc_ext[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (CW'(i) == cnt) begin
        word[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      end
    end
  end

`ifdef FIFO_READ_UPSIZER_LAST_EN
  logic [MAX_UPSIZE_RATIO-1:0] keep_full;
  logic [RATIO-1:0]            out_keep_q;
  logic                        out_last_q;

  assign keep_full    = lanes_to_keep(int'(cnt) + 1, RATIO);
  assign bus.out_keep = out_keep_q;
  assign bus.out_last = out_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (accept && complete) begin
      out_keep_q <= keep_full[RATIO-1:0];
      out_last_q <= bus.in_last;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept && complete) begin
        out_data_q  <= word;
        out_valid_q <= 1'b1;
        cnt         <= '0;
      end else begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
        if (accept) begin
          for (int i = 0; i < RATIO - 1; i++) begin
            if (cnt == CW'(i)) begin
              acc[i*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
            end
          end
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_upsizer.sv
// Directed bench for fifo_read_upsizer at DATA_WIDTH=8, RATIO=4 with hand-computed expected words.
module tb_fifo_read_upsizer;
  import async_fifo_package::*;

  localparam int DW = 8;
  localparam int R  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_read_upsizer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

  fifo_read_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the cycle in which it is accepted.
  task automatic push(input logic [7:0] d);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL push_timeout: beat %0h never accepted", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drops;
    int nwords;
    logic [31:0] wd [2];
    int          wc [2];

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b0;
`ifdef FIFO_READ_UPSIZER_LAST_EN
    bus.in_last   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);

    // Basic pack
    bus.out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    check("basic_partial_valid", bus.out_valid, 0);
    push(8'h44);
    check("basic_valid", bus.out_valid, 1);
    check("basic_data", bus.out_data, 32'h44332211);
    tick();
    check("basic_drained", bus.out_valid, 0);

    // Backpressure
    bus.out_ready = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("bp_word_valid", bus.out_valid, 1);
    push(8'h55); push(8'h66); push(8'h77);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h88;
    #1;
    check("bp_final_stalled", bus.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_hold_valid", bus.out_valid, 1);
    check("bp_hold_data", bus.out_data, 32'h44332211);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_reload_valid", bus.out_valid, 1);
    check("bp_reload_data", bus.out_data, 32'h88776655);
    tick();
    check("bp_drained", bus.out_valid, 0);

    // Streaming
    drops  = 0;
    nwords = 0;
    wd[0] = '0; wd[1] = '0; wc[0] = 0; wc[1] = 0;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      #1;
      if (!bus.in_ready) drops++;
      @(posedge clk); #1;
      if (bus.out_valid) begin
        if (nwords < 2) begin
          wd[nwords] = bus.out_data;
          wc[nwords] = i;
        end
        nwords++;
      end
    end
    bus.in_valid = 1'b0;
    check("stream_ready_drops", drops, 0);
    check("stream_word_count", nwords, 2);
    check("stream_word0", wd[0], 32'h04030201);
    check("stream_word1", wd[1], 32'h08070605);
    check("stream_first_cycle", wc[0], 4);
    check("stream_spacing", wc[1] - wc[0], 4);

    // Reset mid-word
    push(8'hAA); push(8'hBB);
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    tick();
    push(8'h01); push(8'h02);
    check("midrst_no_stale_word", bus.out_valid, 0);
    push(8'h03); push(8'h04);
    check("midrst_valid", bus.out_valid, 1);
    check("midrst_data", bus.out_data, 32'h04030201);
    tick();
    check("midrst_drained", bus.out_valid, 0);

`ifdef FIFO_READ_UPSIZER_LAST_EN
    begin
      logic [MAX_UPSIZE_RATIO-1:0] k;
      k = lanes_to_keep(2, R);
      check("keep_fn_2", k, 32'h3);
      push(8'hAA);
      bus.in_last = 1'b1;
      push(8'hBB);
      bus.in_last = 1'b0;
      check("last_valid", bus.out_valid, 1);
      check("last_data", bus.out_data, 32'h0000BBAA);
      check("last_keep", bus.out_keep, 4'b0011);
      check("last_flag", bus.out_last, 1);
      push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
      check("after_last_data", bus.out_data, 32'hFFEEDDCC);
      check("after_last_keep", bus.out_keep, 4'b1111);
      check("after_last_flag", bus.out_last, 0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_read_upsizer.md
# fifo_read_upsizer

Single-clock width converter on the read side of the async FIFO. It drains DATA_WIDTH-bit beats through a valid/ready handshake and packs RATIO consecutive beats into one DATA_WIDTH*RATIO-bit word, which it presents on a registered valid/ready output. It sits in the read clock domain between the FIFO's r_valid/r_ready/r_data port and a wide downstream consumer.

## Interface
- DATA_WIDTH, 8: input beat width in bits.
- RATIO, 4: beats per output word. Power of two, ≥2.
- clk  input  1: read-domain clock; all logic on rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- in_valid  input  1: input beat available (FIFO r_valid).
- in_data  input  DATA_WIDTH: input beat (FIFO r_data).
- in_ready  output  1: beat accepted when in_valid && in_ready (FIFO r_ready).
- out_valid  output  1: packed word available.
- out_data  output  DATA_WIDTH*RATIO: packed word.
- out_ready  input  1: consumer accepts word when out_valid && out_ready.
- in_last / out_last / out_keep: present only with the configuration macro, see Configuration.

## Operation
- Lane counter cnt, $clog2(RATIO) bits, 0 after reset; points at the next lane to fill.
- Accumulator acc, DATA_WIDTH*(RATIO-1) bits, holds lanes 0..RATIO-2.
- Output register (out_data, out_valid) holds one completed word.
- Lane packing is little-endian: the first beat of a word lands in out_data[DATA_WIDTH-1:0], beat k in bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- Accept on a non-final lane: write in_data into acc lane cnt, cnt <= cnt+1.
- Accept on the final lane (cnt == RATIO-1): load out_data <= {in_data, acc}, out_valid <= 1, cnt <= 0. acc is not cleared.
- in_ready = rst_n && ((cnt != RATIO-1) || !out_valid || out_ready). Non-final lanes never stall. The final lane stalls only while the output register is occupied and not draining.
- Output drain: when out_valid && out_ready and no new word completes that cycle, out_valid <= 0. A simultaneous drain and completion reloads the register, and out_valid stays 1.
- While out_valid && !out_ready, out_data is held stable.
- cnt wraps modulo RATIO. No other arithmetic.
- Reset asserted mid-word discards the partial word and any held output word. No beat is emitted for it.

## Timing
- Reset values: out_valid=0, out_data=0, cnt=0, acc=0. in_ready=0 while rst_n is low, and 1 from the first cycle after release.
- Latency: out_valid rises on the clock edge that accepts the completing beat, so the word is visible in the following cycle.
- Sustained throughput is 1 beat/cycle in and 1 word per RATIO cycles out, with no bubbles when out_ready is held high.
- in_ready is combinational from out_ready and register state only. It has no dependence on in_valid or in_data, except in_last under the macro.

## Configuration
- Macro: FIFO_READ_UPSIZER_LAST_EN.
- Defined: adds in_last (input, 1), out_last (output, 1) and out_keep (output, RATIO).
  - An accepted beat with in_last=1 completes the word in its current lane. Lanes above it are zero in out_data.
  - out_keep is a thermometer mask of filled lanes, e.g. 2 lanes → 4'b0011.
  - out_last=1 for that word. Full words without in_last have out_keep all ones and out_last=0.
  - The final-lane stall term becomes ((cnt != RATIO-1) && !in_last).
  - out_keep and out_last reset to 0.
- Undefined: ports are absent and every word is exactly RATIO beats.

## Structure
- Shared package async_fifo_package gains:
  - DEFAULT_UPSIZE_RATIO constant (4).
  - Function lanes_to_keep(count, ratio), which returns the thermometer keep mask. The bench and RTL both use it.
- No sub-module; counter, accumulator and output register live in one module.

## Test plan
All cases use DATA_WIDTH=8, RATIO=4.
- Reset: hold rst_n=0 with in_valid=1 → in_ready=0, out_valid=0, out_data=0. Release → in_ready=1 next cycle.
- Basic pack: beats 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 → out_valid=1 for one cycle after the 4th accept, out_data=0x44332211.
- Backpressure: hold out_ready=0 after word 0x44332211.
  - Feed 0x55,0x66,0x77,0x88 → first three accepted; in_ready=0 on 0x88 while blocked.
  - Raise out_ready → 0x88 is accepted in the drain cycle, then out_data=0x88776655.
- Streaming: 8 continuous beats 0x01..0x08, out_ready=1 → in_ready never drops; words 0x04030201 then 0x08070605, 4 cycles apart.
- Reset mid-word: accept 0xAA,0xBB, pulse rst_n low, then feed 0x01..0x04 → single word 0x04030201; 0xAA/0xBB never appear.
- With FIFO_READ_UPSIZER_LAST_EN: beats 0xAA, 0xBB (in_last=1) → out_data=0x0000BBAA, out_keep=4'b0011, out_last=1. The next beat 0xCC lands in lane 0.
